// File: rtl/hp_select_ctrl.sv
// Filter-select controller for the highpass biquad: debounces the panel selector and
// switches cutoff through a fade-out / switch / flush / fade-in sequence on sample ticks.
module hp_select_ctrl #(
  parameter int DEBOUNCE      = 1024,
  parameter int MAX_SEL       = 4,
  parameter int RAMP_SHIFT    = 6,
  parameter int FLUSH_SAMPLES = 4
) (
  input  logic               clk_144,
  input  logic               reset_n,
  input  logic               sample_tick,
  input  logic [2:0]         sel_raw,
  input  logic signed [15:0] audio_in,
  output logic [2:0]         filter,
  output logic               filter_clr,
  output logic signed [15:0] audio_out,
  output logic               busy,
  output logic [2:0]         state_dbg
);

  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);
  localparam int GW = RAMP_SHIFT + 1;
  localparam logic [GW-1:0] GAIN_MAX = GW'(1 << RAMP_SHIFT);
  localparam logic [GW-1:0] GAIN_PRE = GW'((1 << RAMP_SHIFT) - 1);
  localparam logic [GW-1:0] GAIN_ONE = GW'(1);
  localparam int FW = (FLUSH_SAMPLES > 1) ? $clog2(FLUSH_SAMPLES) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_SAMPLES - 1);
  localparam logic [2:0] SEL_MAX = 3'(MAX_SEL);
  localparam int PW = (RAMP_SHIFT + 18 > 24) ? RAMP_SHIFT + 18 : 24;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FADE_OUT = 3'd1,
    S_SWITCH   = 3'd2,
    S_FLUSH    = 3'd3,
    S_FADE_IN  = 3'd4
  } state_t;

  state_t          state;
  logic [2:0]      sel_q;
  logic [2:0]      sel_prev;
  logic [DW-1:0]   db_cnt;
  logic [2:0]      sel_stable;
  logic [2:0]      pending;
  logic [GW-1:0]   gain;
  logic [FW-1:0]   flush_cnt;

  logic signed [PW-1:0] audio_ext;
  logic signed [PW-1:0] gain_ext;
  logic signed [PW-1:0] product;

  assign state_dbg = state;

  // A new code is accepted only once the registered value has matched its predecessor
  // for DEBOUNCE consecutive cycles, so a value that changes on the accepting cycle is not taken.
  always_ff @(posedge clk_144 or negedge reset_n) begin
    if (!reset_n) begin
      sel_q      <= 3'd0;
      sel_prev   <= 3'd0;
      db_cnt     <= '0;
      sel_stable <= 3'd0;
    end else begin
      sel_q    <= sel_raw;
      sel_prev <= sel_q;
      if (sel_q != sel_prev) begin
        db_cnt <= '0;
      end else if (db_cnt != DB_LAST) begin
        db_cnt <= db_cnt + DW'(1);
      end
      if ((db_cnt == DB_LAST) && (sel_q == sel_prev)) begin
        sel_stable <= (sel_q > SEL_MAX) ? 3'd0 : sel_q;
      end
    end
  end

  // Gain is zero-extended so the product stays signed; the shift is arithmetic, which
  // makes unity gain bit-exact and negative samples round toward minus infinity.
  assign audio_ext = PW'(audio_in);
  assign gain_ext  = PW'(gain);
  assign product   = audio_ext * gain_ext;

  always_ff @(posedge clk_144 or negedge reset_n) begin
    if (!reset_n) begin
      audio_out <= 16'sd0;
    end else if (sample_tick) begin
      audio_out <= 16'(product >>> RAMP_SHIFT);
    end
  end

  // sample_tick is a one-cycle strobe; every gain and flush step advances only on it,
  // and gain saturates at both ends so it can never wrap.
  always_ff @(posedge clk_144 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      gain       <= GAIN_MAX;
      filter     <= 3'd0;
      filter_clr <= 1'b0;
      busy       <= 1'b0;
      pending    <= 3'd0;
      flush_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sel_stable != filter) begin
            pending <= sel_stable;
            busy    <= 1'b1;
            state   <= S_FADE_OUT;
          end
        end
        S_FADE_OUT: begin
          if (sample_tick) begin
            if (gain != '0) begin
              gain <= gain - GAIN_ONE;
            end
            if (gain <= GAIN_ONE) begin
              state <= S_SWITCH;
            end
          end
        end
        S_SWITCH: begin
          filter     <= pending;
          filter_clr <= 1'b1;
          flush_cnt  <= '0;
          state      <= S_FLUSH;
        end
        S_FLUSH: begin
          if (sample_tick) begin
            if (flush_cnt == FLUSH_LAST) begin
              filter_clr <= 1'b0;
              state      <= S_FADE_IN;
            end else begin
              flush_cnt <= flush_cnt + FW'(1);
            end
          end
        end
        S_FADE_IN: begin
          if (sample_tick) begin
            if (gain != GAIN_MAX) begin
              gain <= gain + GAIN_ONE;
            end
            if (gain >= GAIN_PRE) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hp_select_ctrl.sv
// Bench for hp_select_ctrl: directed scenarios plus random selector/audio traffic, all
// checked every cycle against a tick-indexed behavioural model of the switch sequence.
module tb_hp_select_ctrl;

  localparam int DEB  = 8;
  localparam int MAXS = 4;
  localparam int RS   = 2;
  localparam int FL   = 2;
  localparam int R    = 1 << RS;
  localparam int TICK_PERIOD = 16;

  logic               clk_144 = 1'b0;
  logic               reset_n;
  logic               sample_tick = 1'b0;
  logic [2:0]         sel_raw;
  logic signed [15:0] audio_in;
  logic [2:0]         filter;
  logic               filter_clr;
  logic signed [15:0] audio_out;
  logic               busy;
  logic [2:0]         state_dbg;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  hp_select_ctrl #(
    .DEBOUNCE(DEB), .MAX_SEL(MAXS), .RAMP_SHIFT(RS), .FLUSH_SAMPLES(FL)
  ) dut (
    .clk_144(clk_144), .reset_n(reset_n), .sample_tick(sample_tick), .sel_raw(sel_raw),
    .audio_in(audio_in), .filter(filter), .filter_clr(filter_clr), .audio_out(audio_out),
    .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset / tick ----------------
  always #5 clk_144 = ~clk_144;

  initial begin
    int div;
    div = 0;
    forever begin
      @(negedge clk_144);
      div = (div + 1) % TICK_PERIOD;
      sample_tick = (div == 0);
    end
  end

  // ---------------- behavioural model ----------------
  // A sequence is described by k = ticks consumed since it began; gain is a simple
  // function of k, and the select swap happens on the cycle after tick R.
  int m_filter, m_clr, m_audio, m_busy, m_pending, m_k, m_sw, m_stable;
  int hist[$];

  function automatic int gain_of(input int k);
    if (k <= R) return R - k;
    if (k <= R + FL) return 0;
    return k - R - FL;
  endfunction

  always @(posedge clk_144 or negedge reset_n) begin
    int g;
    bit same;
    if (!reset_n) begin
      m_filter = 0; m_clr = 0; m_audio = 0; m_busy = 0;
      m_pending = 0; m_k = 0; m_sw = 0; m_stable = 0;
      hist.delete();
      hist.push_back(0);
      hist.push_back(0);
    end else begin
      g = !m_busy ? R : (m_sw ? 0 : gain_of(m_k));
      if (sample_tick) m_audio = (int'(audio_in) * g) >>> RS;
      if (!m_busy) begin
        if (m_stable != m_filter) begin
          m_busy = 1; m_pending = m_stable; m_k = 0;
        end
      end else if (m_sw) begin
        m_sw = 0; m_filter = m_pending; m_clr = 1;
      end else if (sample_tick) begin
        m_k++;
        if (m_k == R) m_sw = 1;
        if (m_k == R + FL) m_clr = 0;
        if (m_k == 2 * R + FL) m_busy = 0;
      end
      if (hist.size() == DEB + 1) begin
        same = 1'b1;
        foreach (hist[i]) if (hist[i] != hist[0]) same = 1'b0;
        if (same) m_stable = (hist[DEB] > MAXS) ? 0 : hist[DEB];
      end
      hist.push_back(int'(sel_raw));
      if (hist.size() > DEB + 1) void'(hist.pop_front());
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk_144) begin
    if (chk_en) begin
      check("cyc_filter", int'(filter), m_filter);
      check("cyc_filter_clr", int'(filter_clr), m_clr);
      check("cyc_audio_out", int'(audio_out), m_audio);
      check("cyc_busy", int'(busy), m_busy);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk_144);
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    @(posedge clk_144);
    while (!sample_tick && n < 40) begin
      @(posedge clk_144);
      n++;
    end
    #1;
  endtask

  task automatic wait_for(input string name, input bit use_clr, input logic level, input int max_cyc);
    int n;
    n = 0;
    while (((use_clr ? filter_clr : busy) !== level) && n < max_cyc) begin
      @(negedge clk_144);
      n++;
    end
    check(name, int'(use_clr ? filter_clr : busy), int'(level));
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int exp2[11];
    int got2[11];
    bit busy_seen;
    int hold;
    int pick;
    exp2 = '{1000, 750, 500, 250, 0, 0, 0, 250, 500, 750, 1000};

    reset_n  = 1'b0;
    sel_raw  = 3'd0;
    audio_in = 16'sd1000;
    idle(3);
    chk_en = 1'b1;
    check("rst_filter", int'(filter), 0);
    check("rst_audio_out", int'(audio_out), 0);
    check("rst_busy", int'(busy), 0);
    reset_n = 1'b1;

    // 1: steady state at unity gain
    idle(100);
    check("t1_filter", int'(filter), 0);
    check("t1_busy", int'(busy), 0);
    wait_tick();
    check("t1_unity", int'(audio_out), 1000);

    // 2: full switch to select 2
    @(negedge clk_144);
    sel_raw = 3'd2;
    wait_for("t2_busy_rise", 1'b0, 1'b1, 30);
    for (int i = 0; i < 11; i++) begin
      wait_tick();
      got2[i] = int'(audio_out);
    end
    for (int i = 0; i < 11; i++) check($sformatf("t2_ramp%0d", i), got2[i], exp2[i]);
    check("t2_filter", int'(filter), 2);
    check("t2_busy_end", int'(busy), 0);

    // 3: bouncing selector is never accepted
    busy_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      sel_raw = (i % 2 == 0) ? 3'd3 : 3'd2;
      repeat (5) begin
        @(negedge clk_144);
        if (busy) busy_seen = 1'b1;
      end
    end
    sel_raw = 3'd2;
    idle(20);
    check("t3_busy_seen", int'(busy_seen), 0);
    check("t3_filter", int'(filter), 2);

    // 4: out-of-range code maps to allpass
    sel_raw = 3'd7;
    wait_for("t4_busy_rise", 1'b0, 1'b1, 30);
    wait_for("t4_busy_fall", 1'b0, 1'b0, 300);
    check("t4_filter", int'(filter), 0);

    // 5: change during fade-out is deferred to a second sequence
    sel_raw = 3'd1;
    wait_for("t5_busy_rise", 1'b0, 1'b1, 30);
    wait_tick();
    wait_tick();
    @(negedge clk_144);
    sel_raw = 3'd4;
    wait_for("t5_busy_fall", 1'b0, 1'b0, 300);
    check("t5_filter_first", int'(filter), 1);
    wait_for("t5_busy_rise2", 1'b0, 1'b1, 5);
    wait_for("t5_busy_fall2", 1'b0, 1'b0, 300);
    check("t5_filter_second", int'(filter), 4);

    // 6: asynchronous reset in the middle of the flush
    sel_raw = 3'd2;
    wait_for("t6_busy_rise", 1'b0, 1'b1, 30);
    wait_for("t6_clr_rise", 1'b1, 1'b1, 200);
    @(posedge clk_144);
    #2 reset_n = 1'b0;
    #1;
    check("t6_filter", int'(filter), 0);
    check("t6_filter_clr", int'(filter_clr), 0);
    check("t6_audio_out", int'(audio_out), 0);
    check("t6_busy", int'(busy), 0);
    sel_raw = 3'd0;
    idle(3);
    reset_n  = 1'b1;
    audio_in = -16'sd1000;
    wait_tick();
    check("t6_neg_unity", int'(audio_out), -1000);

    // random selector holds and audio samples, including the extremes
    for (int seg = 0; seg < 40; seg++) begin
      sel_raw = 3'($urandom_range(0, 7));
      hold = $urandom_range(1, 120);
      for (int c = 0; c < hold; c++) begin
        @(negedge clk_144);
        pick = $urandom_range(0, 9);
        if (pick == 0) audio_in = -16'sd32768;
        else if (pick == 1) audio_in = 16'sd32767;
        else audio_in = 16'($urandom);
      end
    end
    idle(400);
    check("end_busy", int'(busy), 0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
